// File: rtl/quant_param_fetch.sv
// ============================================================================
// quant_param_fetch
//
// Fetches per-channel requantisation parameters (int32 multiplier and int32
// shift) from memory over an ICB-style read bus, one group of VLEN channels
// at a time, and presents them lane-parallel to the compute datapath.
//
// Flow per group g (channels g*VLEN .. g*VLEN+cnt-1, cnt = min(VLEN, rest)):
//   REQ   : raise load_req until the bus arbiter grants access.
//   FETCH : read cnt multipliers, then cnt shifts, one read in flight at a
//           time. Lanes at or above cnt are zero.
//   READY : params_valid = 1, lanes frozen until tile_done.
// After the last group, done pulses and the block returns to IDLE.
// An error response parks the block in ERR (sticky err) until the next start.
//
// Ports
//   clk, rstn                    clock, asynchronous active-low reset
//   start                        pulse; latches mult_base, shift_base, n_ch
//   mult_base, shift_base        byte addresses of the int32 arrays
//   n_ch                         total output channels (REG_WIDTH bits)
//   tile_done                    pulse; current group has been consumed
//   load_req / load_grant        bus access request / grant
//   icb_cmd_*                    read command channel (read-only master)
//   icb_rsp_*                    read response channel
//   params_valid                 current group is loaded and stable
//   ch_multiplier, ch_shift      per-lane parameters (VLEN x int32)
//   done                         pulse after the last group is consumed
//   err                          sticky bus error flag
// ============================================================================
module quant_param_fetch #(
    parameter int VLEN      = 16,
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [31:0]          mult_base,
    input  logic [31:0]          shift_base,
    input  logic [REG_WIDTH-1:0] n_ch,
    input  logic                 tile_done,
    output logic                 load_req,
    input  logic                 load_grant,
    output logic                 icb_cmd_valid,
    input  logic                 icb_cmd_ready,
    output logic [31:0]          icb_cmd_addr,
    output logic                 icb_cmd_read,
    input  logic                 icb_rsp_valid,
    output logic                 icb_rsp_ready,
    input  logic [31:0]          icb_rsp_rdata,
    input  logic                 icb_rsp_err,
    output logic                 params_valid,
    output logic signed [31:0]   ch_multiplier [VLEN],
    output logic signed [31:0]   ch_shift      [VLEN],
    output logic                 done,
    output logic                 err
);

    localparam int IW = (VLEN > 1) ? $clog2(VLEN) : 1;  // lane index width
    localparam int CW = $clog2(VLEN + 1);               // group size width

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_FETCH,
        S_READY,
        S_ERR
    } state_e;

    state_e               state_q;
    logic [31:0]          mult_base_q;
    logic [31:0]          shift_base_q;
    logic [REG_WIDTH-1:0] n_ch_q;
    logic [REG_WIDTH-1:0] ch_base_q;   // first channel of the current group (g*VLEN)
    logic [IW-1:0]        idx_q;       // lane being fetched
    logic                 phase_q;     // 0: multipliers, 1: shifts
    logic                 pend_q;      // a read has been accepted, response not yet seen

    logic [REG_WIDTH-1:0] remain;
    logic [CW-1:0]        cnt;
    logic                 last_lane;
    logic                 more_groups;
    logic                 rsp_fire;

    // The master only reads and never back-pressures responses.
    assign icb_cmd_read  = 1'b1;
    assign icb_rsp_ready = 1'b1;

    // Byte address of element (ch + lane) of an int32 array; wraps mod 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0]          base,
                                              input logic [REG_WIDTH-1:0] ch,
                                              input logic [IW-1:0]        lane);
        logic [31:0] elem;
        elem = 32'(ch) + 32'(lane);
        return base + {elem[29:0], 2'b00};
    endfunction

    // NOTE: every always_comb output gets a value on every path (defaults
    // first) so no latch is inferred.
    always_comb begin
        remain      = n_ch_q - ch_base_q;
        cnt         = CW'(VLEN);
        if (remain < REG_WIDTH'(VLEN)) begin
            cnt = CW'(remain);
        end
        last_lane   = (CW'(idx_q) + CW'(1)) == cnt;
        more_groups = remain > REG_WIDTH'(VLEN);
        // Responses only count while a read is genuinely in flight; stray or
        // post-reset responses fall through.
        rsp_fire    = pend_q && icb_rsp_valid;
    end

    // NOTE: state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            mult_base_q   <= '0;
            shift_base_q  <= '0;
            n_ch_q        <= '0;
            ch_base_q     <= '0;
            idx_q         <= '0;
            phase_q       <= 1'b0;
            pend_q        <= 1'b0;
            load_req      <= 1'b0;
            icb_cmd_valid <= 1'b0;
            icb_cmd_addr  <= '0;
            params_valid  <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            // NOTE: the lane arrays are small flop banks visible on the ports,
            // so they are reset like any other register (no stale data after
            // reset).
            for (int i = 0; i < VLEN; i++) begin
                ch_multiplier[i] <= '0;
                ch_shift[i]      <= '0;
            end
        end else begin
            done <= 1'b0;

            case (state_q)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        err          <= 1'b0;
                        ch_base_q    <= '0;
                        mult_base_q  <= mult_base;
                        shift_base_q <= shift_base;
                        n_ch_q       <= n_ch;
                        if (n_ch == '0) begin
                            done    <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            load_req <= 1'b1;
                            state_q  <= S_REQ;
                        end
                    end
                end

                S_REQ: begin
                    if (load_grant) begin
                        load_req      <= 1'b0;
                        state_q       <= S_FETCH;
                        idx_q         <= '0;
                        phase_q       <= 1'b0;
                        pend_q        <= 1'b0;
                        icb_cmd_valid <= 1'b1;
                        icb_cmd_addr  <= word_addr(mult_base_q, ch_base_q, '0);
                        // Unused lanes of a short group must read zero; clear
                        // everything now, the fetched lanes are overwritten.
                        for (int i = 0; i < VLEN; i++) begin
                            ch_multiplier[i] <= '0;
                            ch_shift[i]      <= '0;
                        end
                    end
                end

                S_FETCH: begin
                    if (icb_cmd_valid && icb_cmd_ready) begin
                        icb_cmd_valid <= 1'b0;
                        pend_q        <= 1'b1;
                    end
                    if (rsp_fire) begin
                        pend_q <= 1'b0;
                        if (icb_rsp_err) begin
                            err     <= 1'b1;
                            state_q <= S_ERR;
                        end else begin
                            if (phase_q) begin
                                ch_shift[idx_q]      <= $signed(icb_rsp_rdata);
                            end else begin
                                ch_multiplier[idx_q] <= $signed(icb_rsp_rdata);
                            end
                            // Next command goes out the cycle after this
                            // response, keeping one read in flight at most.
                            if (!last_lane) begin
                                idx_q         <= idx_q + IW'(1);
                                icb_cmd_valid <= 1'b1;
                                icb_cmd_addr  <= word_addr(phase_q ? shift_base_q : mult_base_q,
                                                           ch_base_q, idx_q + IW'(1));
                            end else if (!phase_q) begin
                                phase_q       <= 1'b1;
                                idx_q         <= '0;
                                icb_cmd_valid <= 1'b1;
                                icb_cmd_addr  <= word_addr(shift_base_q, ch_base_q, '0);
                            end else begin
                                params_valid <= 1'b1;
                                state_q      <= S_READY;
                            end
                        end
                    end
                end

                S_READY: begin
                    if (tile_done) begin
                        params_valid <= 1'b0;
                        ch_base_q    <= ch_base_q + REG_WIDTH'(VLEN);
                        if (more_groups) begin
                            load_req <= 1'b1;
                            state_q  <= S_REQ;
                        end else begin
                            done    <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quant_param_fetch.sv
// ============================================================================
// tb_quant_param_fetch
//
// Directed scenarios with randomized memory contents. A bus slave process
// grants access, accepts commands and returns words from a salted hash of
// the address; expected addresses and lane values are computed from the
// group arithmetic (cnt = min(VLEN, n_ch - g*VLEN)) independently of the
// design's internal sequencing.
// ============================================================================
module tb_quant_param_fetch;

    localparam int VLEN = 4;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               start = 1'b0;
    logic [31:0]        mult_base = '0;
    logic [31:0]        shift_base = '0;
    logic [31:0]        n_ch = '0;
    logic               tile_done = 1'b0;
    logic               load_req;
    logic               load_grant = 1'b0;
    logic               icb_cmd_valid;
    logic               icb_cmd_ready = 1'b0;
    logic [31:0]        icb_cmd_addr;
    logic               icb_cmd_read;
    logic               icb_rsp_valid = 1'b0;
    logic               icb_rsp_ready;
    logic [31:0]        icb_rsp_rdata = '0;
    logic               icb_rsp_err = 1'b0;
    logic               params_valid;
    logic signed [31:0] ch_multiplier [VLEN];
    logic signed [31:0] ch_shift      [VLEN];
    logic               done;
    logic               err;

    quant_param_fetch #(.VLEN(VLEN), .REG_WIDTH(32)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .mult_base     (mult_base),
        .shift_base    (shift_base),
        .n_ch          (n_ch),
        .tile_done     (tile_done),
        .load_req      (load_req),
        .load_grant    (load_grant),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err),
        .params_valid  (params_valid),
        .ch_multiplier (ch_multiplier),
        .ch_shift      (ch_shift),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Knobs written only by the main sequence
    // ------------------------------------------------------------------
    int          grant_delay = 0;
    int          ready_delay = 0;
    int unsigned err_at      = 32'hFFFF_FFFF;
    int unsigned spur_req    = 0;
    logic [31:0] salt        = '0;

    // Slave state, written only by the slave process
    int          gcnt        = 0;
    int          wait_ctr    = 0;
    bit          outstanding = 1'b0;
    bit          rsp_pending = 1'b0;
    logic [31:0] rsp_addr    = '0;
    logic [31:0] held_addr   = '0;
    int unsigned resp_count  = 0;
    int unsigned spur_done   = 0;
    int          proto_err   = 0;
    logic [31:0] cmd_log [$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    // Bus slave: all decisions at the falling edge, seen by the DUT at the
    // following rising edge.
    always @(negedge clk) begin
        if (load_req) begin
            if (gcnt >= grant_delay) load_grant = 1'b1;
            else begin
                load_grant = 1'b0;
                gcnt++;
            end
        end else begin
            load_grant = 1'b0;
            gcnt       = 0;
        end

        if (rstn) begin
            if (icb_cmd_valid && outstanding) proto_err++;
            if (icb_cmd_valid && load_req) proto_err++;
            if (wait_ctr > 0 && (!icb_cmd_valid || icb_cmd_addr !== held_addr)) proto_err++;
        end

        icb_rsp_valid = 1'b0;
        icb_rsp_err   = 1'b0;
        icb_rsp_rdata = '0;
        if (spur_req != spur_done) begin
            icb_rsp_valid = 1'b1;
            icb_rsp_err   = 1'b1;
            icb_rsp_rdata = 32'hDEAD_BEEF;
            spur_done++;
        end else if (rsp_pending) begin
            icb_rsp_valid = 1'b1;
            icb_rsp_rdata = mem_word(rsp_addr);
            icb_rsp_err   = (resp_count == err_at);
            resp_count++;
            rsp_pending   = 1'b0;
            outstanding   = 1'b0;
        end

        if (!rstn) begin
            outstanding   = 1'b0;
            wait_ctr      = 0;
            icb_cmd_ready = 1'b0;
        end else if (icb_cmd_valid) begin
            if (wait_ctr == 0) held_addr = icb_cmd_addr;
            if (wait_ctr >= ready_delay) begin
                icb_cmd_ready = 1'b1;
                cmd_log.push_back(icb_cmd_addr);
                rsp_pending   = 1'b1;
                rsp_addr      = icb_cmd_addr;
                outstanding   = 1'b1;
                wait_ctr      = 0;
            end else begin
                icb_cmd_ready = 1'b0;
                wait_ctr++;
            end
        end else begin
            icb_cmd_ready = 1'b0;
            wait_ctr      = 0;
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] mb, input logic [31:0] sb, input logic [31:0] n);
        mult_base  = mb;
        shift_base = sb;
        n_ch       = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic pulse_tile();
        tile_done = 1'b1;
        tick();
        tile_done = 1'b0;
    endtask

    function automatic logic [31:0] exp_lane(input logic [31:0] base, input int n, input int g, input int l);
        int cnt;
        cnt = (n - g * VLEN < VLEN) ? n - g * VLEN : VLEN;
        return (l < cnt) ? mem_word(base + 32'(4 * (g * VLEN + l))) : 32'd0;
    endfunction

    // Wait for group g to load, then check the command sequence since
    // 'mark', the lane contents, and that the lanes hold while valid.
    task automatic expect_group(input string tag, input logic [31:0] mb, input logic [31:0] sb,
                                input int n, input int g, input int mark);
        int          cnt;
        int          t;
        logic [31:0] exp_a;
        logic [31:0] obs_a;
        cnt = (n - g * VLEN < VLEN) ? n - g * VLEN : VLEN;
        t   = 0;
        while (params_valid !== 1'b1 && t < 400) begin
            tick();
            t++;
        end
        check({tag, " params_valid"}, 32'(params_valid), 32'd1);
        check({tag, " cmd count"}, 32'(cmd_log.size() - mark), 32'(2 * cnt));
        for (int i = 0; i < 2 * cnt; i++) begin
            exp_a = ((i < cnt) ? mb : sb) + 32'(4 * (g * VLEN + (i % cnt)));
            obs_a = (mark + i < cmd_log.size()) ? cmd_log[mark + i] : 32'hxxxx_xxxx;
            check($sformatf("%s addr%0d", tag, i), obs_a, exp_a);
        end
        for (int l = 0; l < VLEN; l++) begin
            check($sformatf("%s mult%0d", tag, l), ch_multiplier[l], exp_lane(mb, n, g, l));
            check($sformatf("%s shift%0d", tag, l), ch_shift[l], exp_lane(sb, n, g, l));
        end
        repeat (3) tick();
        check({tag, " hold valid"}, 32'(params_valid), 32'd1);
        check({tag, " hold no cmd"}, 32'(icb_cmd_valid | load_req), 32'd0);
        for (int l = 0; l < VLEN; l++) begin
            check($sformatf("%s hold mult%0d", tag, l), ch_multiplier[l], exp_lane(mb, n, g, l));
            check($sformatf("%s hold shift%0d", tag, l), ch_shift[l], exp_lane(sb, n, g, l));
        end
        check({tag, " err"}, 32'(err), 32'd0);
    endtask

    task automatic expect_zero_outputs(input string tag);
        check({tag, " load_req"}, 32'(load_req), 32'd0);
        check({tag, " cmd_valid"}, 32'(icb_cmd_valid), 32'd0);
        check({tag, " cmd_addr"}, icb_cmd_addr, 32'd0);
        check({tag, " params_valid"}, 32'(params_valid), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " err"}, 32'(err), 32'd0);
        for (int l = 0; l < VLEN; l++) begin
            check($sformatf("%s mult%0d", tag, l), ch_multiplier[l], 32'd0);
            check($sformatf("%s shift%0d", tag, l), ch_shift[l], 32'd0);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int mark;
        int t;
        int seen;
        int pv_seen;
        int n_cmds;

        // Reset state
        tick();
        tick();
        expect_zero_outputs("reset");
        check("reset cmd_read", 32'(icb_cmd_read), 32'd1);
        check("reset rsp_ready", 32'(icb_rsp_ready), 32'd1);
        rstn = 1'b1;
        tick();

        // Scenario 1: n_ch=6, first group, immediate grant, zero-wait slave
        salt = $urandom;
        mark = cmd_log.size();
        do_start(32'h1000, 32'h2000, 32'd6);
        check("s1 load_req", 32'(load_req), 32'd1);
        expect_group("s1 g0", 32'h1000, 32'h2000, 6, 0, mark);

        // Scenario 2: second (short) group, then done
        mark = cmd_log.size();
        pulse_tile();
        check("s2 pv cleared", 32'(params_valid), 32'd0);
        check("s2 load_req", 32'(load_req), 32'd1);
        expect_group("s2 g1", 32'h1000, 32'h2000, 6, 1, mark);
        pulse_tile();
        check("s2 done", 32'(done), 32'd1);
        check("s2 pv off", 32'(params_valid), 32'd0);
        tick();
        check("s2 done pulse", 32'(done), 32'd0);
        check("s2 idle", 32'(load_req | icb_cmd_valid), 32'd0);

        // Scenario 3: n_ch=0
        do_start(32'h1000, 32'h2000, 32'd0);
        check("s3 done", 32'(done), 32'd1);
        seen = int'(load_req | icb_cmd_valid);
        tick();
        check("s3 done pulse", 32'(done), 32'd0);
        repeat (10) begin
            seen |= int'(load_req | icb_cmd_valid);
            tick();
        end
        check("s3 no bus", 32'(seen), 32'd0);

        // Scenario 4: delayed grant, command backpressure, ignored tile_done/start
        salt        = $urandom;
        grant_delay = 10;
        ready_delay = 3;
        mark        = cmd_log.size();
        do_start(32'h3000, 32'h4000, 32'd6);
        tick();
        tick();
        pulse_tile();
        tick();
        check("s4 load_req held", 32'(load_req), 32'd1);
        check("s4 no cmd before grant", 32'(icb_cmd_valid), 32'd0);
        expect_group("s4 g0", 32'h3000, 32'h4000, 6, 0, mark);
        do_start(32'h5555_0000, 32'h6666_0000, 32'd0);
        check("s4 start ignored done", 32'(done), 32'd0);
        check("s4 start ignored pv", 32'(params_valid), 32'd1);
        check("s4 start ignored lane", ch_multiplier[0], exp_lane(32'h3000, 6, 0, 0));
        mark = cmd_log.size();
        pulse_tile();
        expect_group("s4 g1", 32'h3000, 32'h4000, 6, 1, mark);
        pulse_tile();
        check("s4 done", 32'(done), 32'd1);
        check("s4 protocol", 32'(proto_err), 32'd0);
        grant_delay = 0;
        ready_delay = 0;
        tick();

        // Scenario 5: error on the third response, then recovery
        salt    = $urandom;
        err_at  = resp_count + 2;
        mark    = cmd_log.size();
        pv_seen = 0;
        do_start(32'h5000, 32'h6000, 32'd4);
        t = 0;
        while (err !== 1'b1 && t < 200) begin
            pv_seen |= int'(params_valid);
            tick();
            t++;
        end
        check("s5 err", 32'(err), 32'd1);
        n_cmds = cmd_log.size() - mark;
        seen   = 0;
        repeat (20) begin
            seen    |= int'(icb_cmd_valid | load_req);
            pv_seen |= int'(params_valid);
            tick();
        end
        pulse_tile();
        check("s5 cmd count", 32'(n_cmds), 32'd3);
        check("s5 no more cmds", 32'(cmd_log.size() - mark), 32'd3);
        check("s5 quiet", 32'(seen), 32'd0);
        check("s5 pv never", 32'(pv_seen), 32'd0);
        check("s5 err sticky", 32'(err), 32'd1);
        err_at = 32'hFFFF_FFFF;
        mark   = cmd_log.size();
        do_start(32'h5000, 32'h6000, 32'd4);
        check("s5 err cleared", 32'(err), 32'd0);
        check("s5 load_req", 32'(load_req), 32'd1);
        expect_group("s5 g0", 32'h5000, 32'h6000, 4, 0, mark);
        pulse_tile();
        check("s5 done", 32'(done), 32'd1);
        tick();

        // Scenario 6: reset mid-FETCH, late/stray responses afterwards
        salt = $urandom;
        mark = cmd_log.size();
        do_start(32'h7000, 32'h8000, 32'd8);
        t = 0;
        while (!(icb_cmd_valid === 1'b1 && cmd_log.size() - mark >= 3) && t < 200) begin
            tick();
            t++;
        end
        check("s6 mid fetch", 32'(icb_cmd_valid), 32'd1);
        #1 rstn = 1'b0;
        #1;
        expect_zero_outputs("s6 async");
        tick();
        tick();
        rstn = 1'b1;
        spur_req++;
        tick();
        tick();
        tick();
        expect_zero_outputs("s6 post");
        salt = $urandom;
        mark = cmd_log.size();
        do_start(32'h9000, 32'hA000, 32'd3);
        expect_group("s6 g0", 32'h9000, 32'hA000, 3, 0, mark);
        pulse_tile();
        check("s6 done", 32'(done), 32'd1);
        check("s6 protocol", 32'(proto_err), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/quant_param_fetch.md
QUANT_PARAM_FETCH -- requirements
Module: quant_param_fetch

Interface
REQ-001 SHALL have parameters: VLEN, default 16, lanes per group; REG_WIDTH, default 32, config/counter width.
REQ-002 SHALL have ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; latches mult_base, shift_base, n_ch.
- mult_base  in  32  byte address of int32 multiplier array.
- shift_base  in  32  byte address of int32 shift array.
- n_ch  in  REG_WIDTH  total output channels.
- tile_done  in  1  one-cycle pulse; the current group of parameters is consumed.
- load_req  out  1  bus access request.
- load_grant  in  1  bus access grant.
- icb_cmd_valid  out  1  read command valid.
- icb_cmd_ready  in  1  read command ready.
- icb_cmd_addr  out  32  read address.
- icb_cmd_read  out  1  read/write select; always 1.
- icb_rsp_valid  in  1  response valid.
- icb_rsp_ready  out  1  response ready; always 1.
- icb_rsp_rdata  in  32  read data.
- icb_rsp_err  in  1  response error.
- params_valid  out  1  current group is loaded.
- ch_multiplier  out  VLEN x 32 signed  per-lane multiplier.
- ch_shift  out  VLEN x 32 signed  per-lane shift.
- done  out  1  one-cycle pulse after the last group is consumed.
- err  out  1  sticky bus error.

Function
REQ-003 SHALL implement FSM states IDLE, REQ, FETCH, READY, ERR.
REQ-004 SHALL accept start only in IDLE or ERR; in any other state start SHALL be ignored.
REQ-005 Start handling SHALL clear err and zero the group index.
REQ-006 If n_ch==0 at start, the block SHALL pulse done the next cycle, stay in IDLE, and never assert load_req.
REQ-007 If n_ch>0 at start, the block SHALL enter REQ.
REQ-008 In REQ, load_req SHALL be 1 until load_grant is seen high.
REQ-009 On the cycle load_grant is seen high in REQ, the block SHALL enter FETCH and drop load_req.
REQ-010 load_grant SHALL be ignored in every state except REQ.
REQ-011 Group size SHALL be cnt = min(VLEN, n_ch - g*VLEN), where g is the group index.
REQ-012 FETCH SHALL read cnt multipliers from mult_base + 4*(g*VLEN+i), then cnt shifts from shift_base + 4*(g*VLEN+i), for i = 0..cnt-1, in that order.
REQ-013 FETCH SHALL allow at most one outstanding read.
REQ-014 The next command SHALL assert no earlier than the cycle after the previous response handshake.
REQ-015 The first command SHALL assert the cycle after the grant.
REQ-016 icb_cmd_valid and icb_cmd_addr SHALL hold stable until icb_cmd_ready is seen high.
REQ-017 Each response word SHALL be written to lane i of ch_multiplier or ch_shift.
REQ-018 Lanes cnt..VLEN-1 SHALL be set to 0 in both arrays.
REQ-019 After the last shift response, the block SHALL enter READY and assert params_valid the following cycle.
REQ-020 params_valid SHALL be 1 only in READY.
REQ-021 ch_multiplier and ch_shift SHALL be stable while params_valid is 1.
REQ-022 tile_done in READY SHALL clear params_valid and increment g.
REQ-023 After tile_done in READY, the block SHALL enter REQ if channels remain; otherwise it SHALL pulse done and enter IDLE.
REQ-024 tile_done outside READY SHALL be ignored.
REQ-025 An icb_rsp_err=1 response SHALL cause entry to ERR, set err=1, keep params_valid 0, keep load_req 0, and stop further commands.
REQ-026 ERR SHALL be left only via start.
REQ-027 A response arriving with no outstanding command SHALL be ignored.
REQ-028 Address arithmetic SHALL be modulo 2^32.
REQ-029 The channel counter SHALL be REG_WIDTH bits wide.

Reset
REQ-030 While rstn==0, state SHALL be IDLE.
REQ-031 While rstn==0, load_req, icb_cmd_valid, params_valid, done and err SHALL be 0.
REQ-032 While rstn==0, all ch_multiplier and ch_shift lanes SHALL be 0.
REQ-033 While rstn==0, icb_cmd_addr SHALL be 0 and g SHALL be 0.
REQ-034 A reset during FETCH SHALL drop icb_cmd_valid asynchronously.
REQ-035 After a reset, any late response SHALL be ignored.

Verification
REQ-036 Bench SHALL use VLEN=4 and cover:
- Scenario 1: start with n_ch=6, mult_base=0x1000, shift_base=0x2000, immediate grant, zero-wait slave -> first group addresses 0x1000, 0x1004, 0x1008, 0x100C, 0x2000, 0x2004, 0x2008, 0x200C; params_valid rises; lanes match the read data.
- Scenario 2: continue scenario 1, pulse tile_done -> load_req reasserts; addresses 0x1010, 0x1014, 0x2010, 0x2014; lanes 2-3 read 0. Next tile_done -> done pulses for 1 cycle; state is IDLE.
- Scenario 3: start with n_ch=0 -> done pulses the next cycle; load_req and icb_cmd_valid never assert.
- Scenario 4: grant delayed 10 cycles and cmd_ready held low 3 cycles -> no command before the grant; address held stable during backpressure; tile_done pulsed in REQ is ignored.
- Scenario 5: icb_rsp_err on the 3rd response -> err=1; no further commands; params_valid stays 0. A new start clears err and refetches from group 0.
- Scenario 6: rstn asserted mid-FETCH -> all outputs read 0 immediately; no stale lane data after release.
